// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker
//   Receive-side checker for a 2-bit-per-step LFSR random source.
//   Each symbol is {fb1, fb0}: the two new MSBs the generator produced that step.
//   The checker seeds itself from the first W/2 symbols and then predicts every
//   following symbol. It counts mismatches and reports when it is locked.
//   Once locked, the register advances on its own prediction rather than on
//   the received symbol, so an isolated bad symbol does not corrupt later
//   predictions. ERR_LIMIT consecutive mismatches drop the checker back to
//   reseeding.
//   Optional feature macro: LFSR_CHK_BITERR_EN
//     defined   -> err_count adds the number of wrong bits (0..2) per bad symbol
//     undefined -> err_count adds 1 per bad symbol

module lfsr_stream_checker #(
    parameter int W         = 20,
    parameter int TAP0A     = 13,
    parameter int TAP0B     = 2,
    parameter int TAP1A     = 9,
    parameter int TAP1B     = 3,
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             sym_valid,
    input  logic [1:0]       sym,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic             zero_seed,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sym_count
);

    localparam int SYMS  = W / 2;
    localparam int LD_W  = $clog2(SYMS + 1);
    localparam int MIS_W = $clog2(ERR_LIMIT + 1);

    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(SYMS - 1);
    localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(ERR_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Number of set bits in a 2-bit mismatch vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    // Saturating add of a small increment to a counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return CNT_MAX;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    state_t             state_q, state_d;
    logic [W-1:0]       r_q, r_d;
    logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
    logic [MIS_W-1:0]   mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic               zero_seed_q, zero_seed_d;
    logic               err_pulse_q, err_pulse_d;
    logic               lock_lost_q, lock_lost_d;
    logic               locked_q, locked_d;

    // Event-level values before the clear override is applied.
    logic [CNT_W-1:0]   err_evt_s, sym_evt_s;
    logic               zero_evt_s;

    logic [1:0]         pred_s;
    logic [1:0]         miss_s;
    logic [1:0]         err_inc_s;

    assign pred_s = {r_q[TAP1A] ^ r_q[TAP1B], r_q[TAP0A] ^ r_q[TAP0B]};
    assign miss_s = sym ^ pred_s;

`ifdef LFSR_CHK_BITERR_EN
    assign err_inc_s = popcount2(miss_s);
`else
    assign err_inc_s = 2'd1;
`endif

    // Next-state, register, counter and pulse logic for the checker FSM.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        ld_cnt_d    = ld_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        err_evt_s   = err_cnt_q;
        sym_evt_s   = sym_cnt_q;
        zero_evt_s  = zero_seed_q;
        err_pulse_d = 1'b0;
        lock_lost_d = 1'b0;

        if (!enable) begin
            // Disabled: park in IDLE, nothing consumed or counted.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_LOAD;
                    ld_cnt_d  = {LD_W{1'b0}};
                    mis_cnt_d = {MIS_W{1'b0}};
                end
                ST_LOAD: begin
                    if (sym_valid) begin
                        r_d = {sym, r_q[W-1:2]};
                        if (ld_cnt_q == LD_LAST) begin
                            ld_cnt_d = {LD_W{1'b0}};
                            if (r_d == {W{1'b0}}) begin
                                // An all-zero seed can never lock; flag it and reload.
                                zero_evt_s = 1'b1;
                            end else begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            ld_cnt_d = ld_cnt_q + LD_W'(1);
                        end
                    end else begin
                        r_d = r_q;
                    end
                end
                ST_LOCKED: begin
                    if (sym_valid) begin
                        // Flywheel: advance on the prediction, not the received symbol.
                        r_d       = {pred_s, r_q[W-1:2]};
                        sym_evt_s = sat_add(sym_cnt_q, 2'd1);
                        if (miss_s != 2'b00) begin
                            err_pulse_d = 1'b1;
                            err_evt_s   = sat_add(err_cnt_q, err_inc_s);
                            if (mis_cnt_q == MIS_LAST) begin
                                state_d     = ST_LOAD;
                                lock_lost_d = 1'b1;
                                mis_cnt_d   = {MIS_W{1'b0}};
                                ld_cnt_d    = {LD_W{1'b0}};
                            end else begin
                                mis_cnt_d = mis_cnt_q + MIS_W'(1);
                            end
                        end else begin
                            mis_cnt_d = {MIS_W{1'b0}};
                        end
                    end else begin
                        r_d = r_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Clear has priority over any same-cycle count or zero-seed event.
    always_comb begin
        if (clear) begin
            err_cnt_d   = {CNT_W{1'b0}};
            sym_cnt_d   = {CNT_W{1'b0}};
            zero_seed_d = 1'b0;
        end else begin
            err_cnt_d   = err_evt_s;
            sym_cnt_d   = sym_evt_s;
            zero_seed_d = zero_evt_s;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State, LFSR image, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            r_q         <= {W{1'b0}};
            ld_cnt_q    <= {LD_W{1'b0}};
            mis_cnt_q   <= {MIS_W{1'b0}};
            err_cnt_q   <= {CNT_W{1'b0}};
            sym_cnt_q   <= {CNT_W{1'b0}};
            zero_seed_q <= 1'b0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            ld_cnt_q    <= ld_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            err_cnt_q   <= err_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            zero_seed_q <= zero_seed_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign zero_seed = zero_seed_q;
    assign err_count = err_cnt_q;
    assign sym_count = sym_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Testbench for lfsr_stream_checker: directed symbol streams from a reference
// generator, a stream-level model of what the checker must report, and
// hand-computed literal expectations at key points.
// A second instance with narrow counters checks saturation.

module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic        sym_valid;
    logic [1:0]  sym;

    logic        locked, err_pulse, lock_lost, zero_seed;
    logic [15:0] err_count, sym_count;
    logic        s_locked, s_err_pulse, s_lock_lost, s_zero_seed;
    logic [4:0]  s_err_count, s_sym_count;

    lfsr_stream_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .sym_valid(sym_valid), .sym(sym),
        .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
        .zero_seed(zero_seed), .err_count(err_count), .sym_count(sym_count)
    );

    lfsr_stream_checker #(.CNT_W(5)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .sym_valid(sym_valid), .sym(sym),
        .locked(s_locked), .err_pulse(s_err_pulse), .lock_lost(s_lock_lost),
        .zero_seed(s_zero_seed), .err_count(s_err_count), .sym_count(s_sym_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference generator state (stimulus source).
    logic [19:0] gen_q;

    // Model: mode 0=idle, 1=seeding, 2=locked; counts kept unbounded.
    int          m_mode, m_ld, m_mis, m_err, m_sym;
    logic [19:0] m_st;
    logic        m_zs, m_pulse, m_lost;

    // The generator's next symbol for a given 20-bit state.
    function automatic logic [1:0] gen_fb(input logic [19:0] st);
        return {st[9] ^ st[3], st[13] ^ st[2]};
    endfunction

    function automatic logic [31:0] sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ld = 0; m_mis = 0; m_err = 0; m_sym = 0;
        m_st = 20'h0; m_zs = 1'b0; m_pulse = 1'b0; m_lost = 1'b0;
    endtask

    // Apply one clock edge of the sampled inputs to the model.
    task automatic model_clock();
        logic [1:0] p;
        int inc;
        m_pulse = 1'b0;
        m_lost  = 1'b0;
        if (!enable) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_ld = 0; m_mis = 0;
        end else if (m_mode == 1) begin
            if (sym_valid) begin
                m_st = {sym, m_st[19:2]};
                m_ld++;
                if (m_ld == 10) begin
                    m_ld = 0;
                    if (m_st == 20'h0) m_zs = 1'b1;
                    else m_mode = 2;
                end
            end
        end else begin
            if (sym_valid) begin
                p = gen_fb(m_st);
                m_st = {p, m_st[19:2]};
                m_sym++;
                if (sym !== p) begin
`ifdef LFSR_CHK_BITERR_EN
                    inc = $countones(sym ^ p);
`else
                    inc = 1;
`endif
                    m_pulse = 1'b1;
                    m_err += inc;
                    m_mis++;
                    if (m_mis == 3) begin
                        m_mode = 1; m_lost = 1'b1; m_mis = 0; m_ld = 0;
                    end
                end else begin
                    m_mis = 0;
                end
            end
        end
        if (clear) begin
            m_err = 0; m_sym = 0; m_zs = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("locked",      {31'd0, locked},    {31'd0, m_mode == 2});
        chk("err_pulse",   {31'd0, err_pulse}, {31'd0, m_pulse});
        chk("lock_lost",   {31'd0, lock_lost}, {31'd0, m_lost});
        chk("zero_seed",   {31'd0, zero_seed}, {31'd0, m_zs});
        chk("err_count",   {16'd0, err_count}, sat(m_err, 16));
        chk("sym_count",   {16'd0, sym_count}, sat(m_sym, 16));
        chk("sat_err_cnt", {27'd0, s_err_count}, sat(m_err, 5));
        chk("sat_sym_cnt", {27'd0, s_sym_count}, sat(m_sym, 5));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_model();
    endtask

    task automatic send(input logic [1:0] s, input logic v);
        sym = s;
        sym_valid = v;
        step();
    endtask

    task automatic next_gen(output logic [1:0] s);
        s = gen_fb(gen_q);
        gen_q = {s, gen_q[19:2]};
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; clear = 1'b0; sym_valid = 1'b0; sym = 2'b00;
        model_reset();
        #1;
        check_model();
        chk("rst_locked", {31'd0, locked},    32'd0);
        chk("rst_errcnt", {16'd0, err_count}, 32'd0);
        chk("rst_symcnt", {16'd0, sym_count}, 32'd0);
        chk("rst_zseed",  {31'd0, zero_seed}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start();
        enable = 1'b1;
        send(2'b00, 1'b0);
    endtask

    logic [1:0] g;
    logic [1:0] exp7 [7];

    initial begin
        exp7 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
        rst = 1'b0; enable = 1'b0; clear = 1'b0; sym_valid = 1'b0; sym = 2'b00;
        @(negedge clk);
        do_reset();

        // Clean contiguous stream from seed FFFFF.
        gen_q = 20'hFFFFF;
        start();
        for (int i = 1; i <= 200; i++) begin
            next_gen(g);
            if (i <= 7) chk("gen_sym", {30'd0, g}, {30'd0, exp7[i-1]});
            send(g, 1'b1);
            if (i == 9)  chk("lock_pre10", {31'd0, locked}, 32'd0);
            if (i == 10) chk("lock_at10",  {31'd0, locked}, 32'd1);
        end
        chk("t1_locked", {31'd0, locked},      32'd1);
        chk("t1_err",    {16'd0, err_count},   32'd0);
        chk("t1_sym",    {16'd0, sym_count},   32'd190);
        chk("t1_satsym", {27'd0, s_sym_count}, 32'd31);

        // Single flipped bit while locked.
        next_gen(g);
        send(g ^ 2'b01, 1'b1);
        chk("t2_pulse", {31'd0, err_pulse}, 32'd1);
        next_gen(g);
        send(g, 1'b1);
        chk("t2_pulse_end", {31'd0, err_pulse}, 32'd0);
        chk("t2_err",       {16'd0, err_count}, 32'd1);
        chk("t2_locked",    {31'd0, locked},    32'd1);
        for (int i = 0; i < 5; i++) begin
            next_gen(g);
            send(g, 1'b1);
        end

        // Clear together with a counted symbol: clear wins.
        next_gen(g);
        clear = 1'b1;
        send(g, 1'b1);
        clear = 1'b0;
        chk("clear_wins", {16'd0, sym_count}, 32'd0);

        // Three inverted symbols force a resync, then relock.
        for (int k = 0; k < 3; k++) begin
            next_gen(g);
            send(~g, 1'b1);
        end
        chk("t3_lost",   {31'd0, lock_lost}, 32'd1);
        chk("t3_locked", {31'd0, locked},    32'd0);
`ifdef LFSR_CHK_BITERR_EN
        chk("t3_err", {16'd0, err_count}, 32'd6);
`else
        chk("t3_err", {16'd0, err_count}, 32'd3);
`endif
        for (int j = 1; j <= 10; j++) begin
            next_gen(g);
            send(g, 1'b1);
            if (j == 1)  chk("t3_lost_end", {31'd0, lock_lost}, 32'd0);
            if (j == 9)  chk("t3_relock9",  {31'd0, locked},    32'd0);
            if (j == 10) chk("t3_relock10", {31'd0, locked},    32'd1);
        end

        // Five isolated errors, then clear leaves lock state alone.
        next_gen(g);
        clear = 1'b1;
        send(g, 1'b1);
        clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_gen(g);
            send(g ^ 2'b01, 1'b1);
            next_gen(g);
            send(g, 1'b1);
            next_gen(g);
            send(g, 1'b1);
        end
        chk("t6_err5", {16'd0, err_count}, 32'd5);
        clear = 1'b1;
        send(2'b00, 1'b0);
        clear = 1'b0;
        chk("t6_clr_err", {16'd0, err_count}, 32'd0);
        chk("t6_clr_sym", {16'd0, sym_count}, 32'd0);
        chk("t6_clr_lck", {31'd0, locked},    32'd1);

        // Enable drop while locked: symbol not counted, lock drops.
        enable = 1'b0;
        next_gen(g);
        send(g, 1'b1);
        chk("dis_sym",    {16'd0, sym_count}, 32'd0);
        chk("dis_locked", {31'd0, locked},    32'd0);

        // Relock, then reset mid-LOCKED.
        start();
        for (int j = 0; j < 14; j++) begin
            next_gen(g);
            send(g, 1'b1);
        end
        chk("pre_rst_lock", {31'd0, locked}, 32'd1);
        do_reset();

        // All-zero seed, then a real stream.
        start();
        for (int j = 0; j < 10; j++) send(2'b00, 1'b1);
        chk("t4_zseed",  {31'd0, zero_seed}, 32'd1);
        chk("t4_locked", {31'd0, locked},    32'd0);
        gen_q = 20'hFFFFF;
        for (int j = 1; j <= 12; j++) begin
            next_gen(g);
            send(g, 1'b1);
            if (j == 10) chk("t4_lock10", {31'd0, locked}, 32'd1);
        end
        chk("t4_sticky", {31'd0, zero_seed}, 32'd1);
        clear = 1'b1;
        send(2'b00, 1'b0);
        clear = 1'b0;
        chk("t4_zs_clr", {31'd0, zero_seed}, 32'd0);

        // 50% duty stream with junk on idle cycles.
        do_reset();
        gen_q = 20'hFFFFF;
        start();
        for (int i = 1; i <= 200; i++) begin
            next_gen(g);
            send(g, 1'b1);
            send(2'($urandom), 1'b0);
        end
        chk("t5_locked", {31'd0, locked},    32'd1);
        chk("t5_err",    {16'd0, err_count}, 32'd0);
        chk("t5_sym",    {16'd0, sym_count}, 32'd190);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
